// File: rtl/top99_counter_display_if.sv
// top99_counter_display_if: enable input and multiplexed 7-segment outputs of the counter display
interface top99_counter_display_if;
  logic       en;
  logic [3:0] sel;
  logic [6:0] seg;
  modport master (output en, input sel, seg);
  modport slave  (input en, output sel, seg);
endinterface

// File: rtl/top99_counter_display.sv
// top99_counter_display: 00..99 BCD counter on a 4-digit muxed 7-seg display; `LEADING_ZERO_BLANK_EN blanks a zero tens digit
module top99_counter_display #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input logic                      clk_50mhz,
  input logic                      rst,
  top99_counter_display_if.slave   bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [3:0] BLANK = 4'hf;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    units_q, units_d, tens_q, tens_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic          tick, scan_wrap;
  logic [3:0]    digit;
  // next-state: prescaler holds while disabled, BCD digits advance on tick, scan free-runs
  always_comb begin
    tick      = bus.en && pre_q == PW'(TICK_DIV - 1);
    scan_wrap = scan_q == SW'(SCAN_DIV - 1);
    pre_d     = !bus.en ? pre_q : tick ? '0 : pre_q + 1'b1;
    units_d   = !tick ? units_q : units_q == 4'd9 ? 4'd0 : units_q + 4'd1;
    tens_d    = !(tick && units_q == 4'd9) ? tens_q : tens_q == 4'd9 ? 4'd0 : tens_q + 4'd1;
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;
  end
  // state registers with synchronous active-low reset taking priority over everything
  always_ff @(posedge clk_50mhz) begin
    if (!rst) begin
      pre_q   <= '0;
      units_q <= '0;
      tens_q  <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
    end
  end
  // choose the digit for the active slot; slots 2 and 3 are always blank
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    digit = idx_q == 2'd0 ? units_q : (idx_q == 2'd1 && tens_q != 4'd0) ? tens_q : BLANK;
`else
    digit = idx_q == 2'd0 ? units_q : idx_q == 2'd1 ? tens_q : BLANK;
`endif
    bus.sel = ~(4'b0001 << idx_q);
  end
  // active-low gfedcba decode; any non-decimal code shows blank
  always_comb begin
    case (digit)
      4'd0:    bus.seg = 7'b1000000;
      4'd1:    bus.seg = 7'b1111001;
      4'd2:    bus.seg = 7'b0100100;
      4'd3:    bus.seg = 7'b0110000;
      4'd4:    bus.seg = 7'b0011001;
      4'd5:    bus.seg = 7'b0010010;
      4'd6:    bus.seg = 7'b0000010;
      4'd7:    bus.seg = 7'b1111000;
      4'd8:    bus.seg = 7'b0000000;
      4'd9:    bus.seg = 7'b0010000;
      default: bus.seg = 7'b1111111;
    endcase
  end
endmodule

// File: tb/tb_top99_counter_display.sv
// tb_top99_counter_display: randomized and directed checks of the counter display against a cycle-count model
module tb_top99_counter_display;
  localparam int TD = 4;
  localparam int SD = 2;
  localparam logic [6:0] SEG [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b1111111};
  logic clk = 1'b0;
  logic rst;
  int   n_en, m, ncmp, nerr;
  top99_counter_display_if bus ();
  top99_counter_display #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (.clk_50mhz(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // model: count = enabled cycles since reset / TD mod 100; slot = cycles since reset / SD mod 4
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      n_en = 0;
      m = 0;
    end else begin
      m++;
      if (bus.en) n_en++;
    end
    #1;
  endtask
  function automatic logic [3:0] exp_sel();
    return ~(4'b0001 << ((m / SD) % 4));
  endfunction
  function automatic logic [6:0] exp_seg();
    int c = (n_en / TD) % 100;
    int i = (m / SD) % 4;
    if (i == 0) return SEG[c % 10];
    if (i != 1) return SEG[10];
`ifdef LEADING_ZERO_BLANK_EN
    if (c / 10 == 0) return SEG[10];
`endif
    return SEG[c / 10];
  endfunction
  task automatic test_reset();
    rst = 1'b0;
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      ncmp += 2;
      if (bus.sel !== 4'b1110) begin nerr++; $display("FAIL reset_sel got %b want 1110", bus.sel); end
      if (bus.seg !== 7'b1000000) begin nerr++; $display("FAIL reset_seg got %b want 1000000", bus.seg); end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      ncmp++;
      if (bus.seg !== 7'b1000000 || bus.sel !== 4'b1110) begin
        nerr++; $display("FAIL reset_prio got sel=%b seg=%b want sel=1110 seg=1000000", bus.sel, bus.seg);
      end
    end
  endtask
  task automatic test_count();
    rst = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      ncmp++;
      if (bus.sel !== exp_sel() || bus.seg !== exp_seg()) begin
        nerr++; $display("FAIL count cyc %0d got sel=%b seg=%b want sel=%b seg=%b", i, bus.sel, bus.seg, exp_sel(), exp_seg());
      end
    end
    bus.en = 1'b0;
    ncmp += 2;
    if (bus.sel !== 4'b1110) begin nerr++; $display("FAIL count10_sel0 got %b want 1110", bus.sel); end
    if (bus.seg !== 7'b1000000) begin nerr++; $display("FAIL count10_units got %b want 1000000", bus.seg); end
    step(); step();
    ncmp += 2;
    if (bus.sel !== 4'b1101) begin nerr++; $display("FAIL count10_sel1 got %b want 1101", bus.sel); end
    if (bus.seg !== 7'b1111001) begin nerr++; $display("FAIL count10_tens got %b want 1111001", bus.seg); end
  endtask
  task automatic test_wrap();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 396; i++) begin
      step();
      ncmp++;
      if (bus.sel !== exp_sel() || bus.seg !== exp_seg()) begin
        nerr++; $display("FAIL wrap cyc %0d got sel=%b seg=%b want sel=%b seg=%b", i, bus.sel, bus.seg, exp_sel(), exp_seg());
      end
    end
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    ncmp++;
    if (bus.sel !== 4'b1110 || bus.seg !== 7'b0010000) begin
      nerr++; $display("FAIL wrap99_units got sel=%b seg=%b want sel=1110 seg=0010000", bus.sel, bus.seg);
    end
    step(); step();
    ncmp++;
    if (bus.sel !== 4'b1101 || bus.seg !== 7'b0010000) begin
      nerr++; $display("FAIL wrap99_tens got sel=%b seg=%b want sel=1101 seg=0010000", bus.sel, bus.seg);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.en = 1'b0;
    step(); step();
    ncmp++;
    if (bus.sel !== 4'b1110 || bus.seg !== 7'b1000000) begin
      nerr++; $display("FAIL wrap00_units got sel=%b seg=%b want sel=1110 seg=1000000", bus.sel, bus.seg);
    end
    step(); step();
    ncmp++;
`ifdef LEADING_ZERO_BLANK_EN
    if (bus.seg !== 7'b1111111) begin nerr++; $display("FAIL wrap00_tens got %b want 1111111", bus.seg); end
`else
    if (bus.seg !== 7'b1000000) begin nerr++; $display("FAIL wrap00_tens got %b want 1000000", bus.seg); end
`endif
  endtask
  task automatic test_hold();
    logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      ncmp += 2;
      if (bus.sel !== rot[(m / SD) % 4]) begin nerr++; $display("FAIL hold_rot cyc %0d got %b want %b", i, bus.sel, rot[(m / SD) % 4]); end
      if (bus.seg !== exp_seg()) begin nerr++; $display("FAIL hold_seg cyc %0d got %b want %b", i, bus.seg, exp_seg()); end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      ncmp++;
      if (bus.sel !== exp_sel() || bus.seg !== exp_seg()) begin
        nerr++; $display("FAIL hold_resume cyc %0d got sel=%b seg=%b want sel=%b seg=%b", i, bus.sel, bus.seg, exp_sel(), exp_seg());
      end
    end
  endtask
  task automatic test_leading_zero();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 20; i++) step();
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    ncmp++;
    if (bus.sel !== 4'b1110 || bus.seg !== 7'b0010010) begin
      nerr++; $display("FAIL lz_units got sel=%b seg=%b want sel=1110 seg=0010010", bus.sel, bus.seg);
    end
    step(); step();
    ncmp++;
`ifdef LEADING_ZERO_BLANK_EN
    if (bus.seg !== 7'b1111111) begin nerr++; $display("FAIL lz_tens got %b want 1111111", bus.seg); end
`else
    if (bus.seg !== 7'b1000000) begin nerr++; $display("FAIL lz_tens got %b want 1000000", bus.seg); end
`endif
  endtask
  task automatic test_random();
    for (int i = 0; i < 700; i++) begin
      rst = $urandom_range(0, 79) != 0;
      bus.en = $urandom_range(0, 3) != 0;
      step();
      ncmp += 3;
      if (bus.sel !== exp_sel()) begin nerr++; $display("FAIL rand_sel cyc %0d got %b want %b", i, bus.sel, exp_sel()); end
      if (bus.seg !== exp_seg()) begin nerr++; $display("FAIL rand_seg cyc %0d got %b want %b", i, bus.seg, exp_seg()); end
      if ($countones(~bus.sel) != 1 || ((bus.sel[2] == 1'b0 || bus.sel[3] == 1'b0) && bus.seg !== 7'b1111111)) begin
        nerr++; $display("FAIL rand_blank cyc %0d got sel=%b seg=%b want one low sel and blank in slots 2/3", i, bus.sel, bus.seg);
      end
    end
  endtask
  initial begin
    ncmp = 0;
    nerr = 0;
    n_en = 0;
    m = 0;
    rst = 1'b0;
    bus.en = 1'b0;
    test_reset();
    test_count();
    test_wrap();
    test_hold();
    test_leading_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
